// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding, prescale codes and setting decoder for the clock divider front-end
package clk_div_pkg;
  localparam int CFG_W = 5;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, LOAD, SETTLE} state_t;
  typedef struct packed {
    logic             legal;
    logic [CFG_W-1:0] ratio;
  } decode_t;
  // Prescale 32 does not fit in CFG_W bits, so code 0 stands for it
  localparam logic [CFG_W-1:0] PRESC_32 = CFG_W'(0);
  localparam logic [CFG_W-1:0] PRESC_16 = CFG_W'(16);
  localparam logic [CFG_W-1:0] PRESC_8  = CFG_W'(8);
  localparam logic [CFG_W-1:0] PRESC_4  = CFG_W'(4);
  function automatic decode_t presc_decode(input logic mode, input logic [CFG_W-1:0] value);
    decode_t d;
    d.legal = mode ? (value == PRESC_32 || value == PRESC_16 || value == PRESC_8 || value == PRESC_4)
                   : (value != '0);
    d.ratio = !mode              ? value :
              value == PRESC_32 ? CFG_W'(1) :
              value == PRESC_16 ? CFG_W'(2) :
              value == PRESC_8  ? CFG_W'(4) : CFG_W'(8);
    return d;
  endfunction
endpackage

// File: rtl/clk_div_presc_decode.sv
// clk_div_presc_decode: combinational mode/code to {legal, ratio} decoder
module clk_div_presc_decode import clk_div_pkg::*; (
  input  logic             mode,
  input  logic [CFG_W-1:0] value,
  output logic             legal,
  output logic [CFG_W-1:0] ratio
);
  decode_t d;
  assign d     = presc_decode(mode, value);
  assign legal = d.legal;
  assign ratio = d.ratio;
endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl: validates divider settings and reconfigures the divider without runt pulses
module clk_div_cfg_ctrl import clk_div_pkg::*; #(
  parameter int RATIO_WIDTH   = CFG_W,
  parameter int DEFAULT_RATIO = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic                   i_cfg_mode,
  input  logic [RATIO_WIDTH-1:0] i_cfg_value,
  output logic                   o_clk_en,
  output logic [RATIO_WIDTH-1:0] o_div_ratio,
  output logic                   o_bypass,
  output logic                   o_cfg_err,
  output logic                   o_busy
);
  state_t                 state, state_n;
  logic [RATIO_WIDTH-1:0] cnt, cnt_n, held, held_n, ratio_n, dec_ratio;
  logic                   stop, stop_n, bypass_n, xfer, legal;
  clk_div_presc_decode u_dec (
    .mode  (i_cfg_mode),
    .value (i_cfg_value),
    .legal (legal),
    .ratio (dec_ratio)
  );
  assign o_cfg_ready = state == IDLE || state == RUN;
  assign xfer        = i_cfg_valid && o_cfg_ready;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stop_n   = stop;
    held_n   = xfer && legal ? dec_ratio : held;
    ratio_n  = o_div_ratio;
    bypass_n = o_bypass;
    unique case (state)
      IDLE: begin
        if (xfer ? legal : i_en && held > RATIO_WIDTH'(1)) state_n = LOAD;
      end
      RUN: begin
        // Drain one full period of the old ratio so the last divided pulse completes
        if ((xfer && legal) || !i_en) begin
          state_n = DRAIN;
          cnt_n   = o_div_ratio - RATIO_WIDTH'(1);
          stop_n  = !i_en;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_n = stop ? IDLE : LOAD;
        else cnt_n = cnt - RATIO_WIDTH'(1);
      end
      LOAD: begin
        state_n  = SETTLE;
        cnt_n    = RATIO_WIDTH'(SETTLE_CYCLES - 1);
        ratio_n  = held;
        bypass_n = held == RATIO_WIDTH'(1);
      end
      SETTLE: begin
        if (cnt == '0) state_n = i_en ? RUN : IDLE;
        else cnt_n = cnt - RATIO_WIDTH'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      stop        <= 1'b0;
      held        <= RATIO_WIDTH'(DEFAULT_RATIO);
      o_div_ratio <= RATIO_WIDTH'(DEFAULT_RATIO);
      o_bypass    <= 1'b0;
      o_clk_en    <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      stop        <= stop_n;
      held        <= held_n;
      o_div_ratio <= ratio_n;
      o_bypass    <= bypass_n;
      o_clk_en    <= state_n == RUN && !bypass_n;
      o_cfg_err   <= xfer && !legal;
      o_busy      <= state_n inside {DRAIN, LOAD, SETTLE};
    end
  end
endmodule

// File: doc/clk_div_cfg_ctrl.md
Name: clk_div_cfg_ctrl

Overview:
- Configuration front-end for the integer clock divider. Drives the divider's enable and ratio inputs.
- Accepts new divide settings from the register file over a valid/ready handshake. Two setting formats: a direct ratio, or a UART prescale code.
- Validates each setting. Changes the divider ratio only while the divider enable is low, after a drain window, so the divided clock never produces a runt pulse during reconfiguration.
- Sits between the register file and the clock divider, in the i_ref_clk domain.

Parameters:
- RATIO_WIDTH, 5, width of the ratio and prescale fields and of all internal counters.
- DEFAULT_RATIO, 2, value of o_div_ratio out of reset.
- SETTLE_CYCLES, 2, number of i_ref_clk cycles o_div_ratio is held stable before enable rises. Range 1..2^RATIO_WIDTH-1.

Ports:
- i_ref_clk  input  1  reference clock; the only clock.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_en  input  1  global divider enable from the register file.
- i_cfg_valid  input  1  new configuration request.
- o_cfg_ready  output  1  controller can accept a request this cycle.
- i_cfg_mode  input  1  0 = i_cfg_value is a direct ratio; 1 = i_cfg_value is a prescale code.
- i_cfg_value  input  RATIO_WIDTH  ratio or prescale code.
- o_clk_en  output  1  drives the divider's i_clk_en.
- o_div_ratio  output  RATIO_WIDTH  drives the divider's i_div_ratio.
- o_bypass  output  1  1 = divide-by-1 is active; the divider is disabled and downstream muxes select i_ref_clk.
- o_cfg_err  output  1  one-cycle pulse when a request is rejected.
- o_busy  output  1  high in DRAIN, LOAD and SETTLE.

Behaviour:
- Reset (i_rst_n low at a rising edge of i_ref_clk) gives these register values:
  - o_clk_en = 0, o_div_ratio = DEFAULT_RATIO, o_bypass = 0, o_cfg_err = 0, o_busy = 0.
  - State = IDLE; the held (captured) ratio = DEFAULT_RATIO.
  - o_cfg_ready = 1, derived from IDLE.
- Reset asserted in any state returns all of the above at the next edge.
- Handshake:
  - o_cfg_ready = 1 in IDLE and RUN, 0 otherwise. It is combinational from the state.
  - A transfer occurs on a rising edge where i_cfg_valid && o_cfg_ready.
  - Requests while o_cfg_ready = 0 are ignored, not queued.
- Validation and decoding, done at transfer:
  - Mode 0: value 0 is illegal; any other value becomes the new ratio.
  - Mode 1: prescale 32 -> 1, 16 -> 2, 8 -> 4, 4 -> 8; all other codes are illegal.
  - Prescale 32 needs 6 bits. With RATIO_WIDTH = 5 it is unreachable, so the encoding is 5'b00000 = 32, i.e. code 0 in mode 1 means 32.
  - Illegal request: o_cfg_err = 1 for exactly one cycle, state unchanged, held ratio unchanged.
  - Legal request: the new ratio is captured. New bypass = (ratio == 1).
- State machine:
  - IDLE: o_clk_en = 0.
    - Legal transfer -> LOAD.
    - i_en = 1 with no transfer, and held ratio >= 2 -> LOAD, to re-enable the held ratio.
  - RUN: o_clk_en = 1 unless o_bypass = 1.
    - Legal transfer -> DRAIN, counter = o_div_ratio - 1.
    - i_en = 0 -> DRAIN, then go to IDLE instead of LOAD.
    - If both occur in the same cycle, the transfer is captured and the destination after DRAIN is IDLE.
  - DRAIN: o_clk_en = 0 from the first DRAIN cycle. Counter decrements each cycle. At 0 -> LOAD, or -> IDLE if i_en = 0 was latched.
  - LOAD: one cycle. o_div_ratio and o_bypass update from the captured values at this edge. Counter = SETTLE_CYCLES - 1. -> SETTLE.
  - SETTLE: counter decrements. At 0 -> RUN if i_en = 1, else -> IDLE.
- Latencies:
  - From RUN: transfer to o_clk_en rising = 1 (DRAIN entry) + old_ratio + 1 + SETTLE_CYCLES edges.
  - From IDLE (no drain): o_clk_en rises 2 + SETTLE_CYCLES edges after the transfer.
- Rules on the divider outputs:
  - o_div_ratio never changes while o_clk_en = 1.
  - o_clk_en is never 1 while o_bypass = 1.
- All counters are RATIO_WIDTH bits and never wrap. A counter already at 0 on entry exits on the next edge.

Decomposition:
- Shared package clk_div_pkg contains:
  - state encoding: IDLE, RUN, DRAIN, LOAD, SETTLE;
  - prescale code constants: PRESC_32 = 0, PRESC_16 = 16, PRESC_8 = 8, PRESC_4 = 4;
  - a decode function returning {legal, ratio}.
- One natural sub-module: clk_div_presc_decode, the combinational mode/code -> {legal, ratio} decoder. The FSM and counters stay in the top module.

Test Plan:
- Reset, then i_en = 1 with no request -> o_clk_en = 1 after 2 + SETTLE_CYCLES edges (4 with the default), o_div_ratio = 2 throughout.
- In RUN at ratio 2, request mode 0 value 8 -> o_clk_en falls next edge and stays low for 2 + 1 + 2 cycles. o_div_ratio = 8 only while o_clk_en = 0. Then RUN with o_clk_en = 1.
- Request mode 1 code 16 -> ratio 2. Code 0 -> ratio 1, o_bypass = 1, o_clk_en stays 0. Code 5 -> o_cfg_err one-cycle pulse, outputs unchanged.
- Request mode 0 value 0 in RUN -> o_cfg_err pulse, o_clk_en stays 1, no drain.
- Drop i_en together with a request for 3 in RUN -> drain, then IDLE, o_clk_en = 0. Raise i_en later -> runs at ratio 3.
- Assert i_rst_n = 0 mid-DRAIN at ratio 7 -> next edge: IDLE, o_div_ratio = 2, o_clk_en = 0, o_busy = 0. Requests issued during DRAIN are never accepted (o_cfg_ready = 0).
